axi_wr_master: RTL and testbench

//  AXI4 write master directly downstream of the DDR write-burst controller.

---
 rtl/axi_wr_master.sv | 186 ++++++++++++++++++
 tb/tb_axi_wr_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_master.sv
// AXI4 write master fed by the DDR write-burst controller. Takes one burst
// request at a time, prefetches beats from the controller's write FIFO into a
// 2-entry skid buffer, and drives AW/W/B to the memory controller.
module axi_wr_master #(
    parameter int          DATA_WIDTH = 256,
    parameter int          ADDR_SHIFT = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          ID_WIDTH   = 4,
    parameter int          AXI_ID     = 0
) (
    input  logic                      ui_clk,
    input  logic                      ui_rst,
    input  logic                      wr_burst_req,
    input  logic [31:0]               wr_burst_addr,
    input  logic [9:0]                wr_burst_len,
    output logic                      wr_ready,
    output logic                      wr_fifo_re,
    input  logic [DATA_WIDTH-1:0]     wr_fifo_data,
    output logic                      wr_burst_finish,
    output logic [1:0]                wr_err,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [31:0]               m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);

    localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE, S_HOLD} state_t;

    state_t                r_state;
    logic [31:0]           r_awaddr;
    logic [7:0]            r_awlen;
    logic                  r_awvalid;
    logic                  r_bready;
    logic                  r_finish;
    logic [1:0]            r_err;
    logic [8:0]            r_beats;
    logic [8:0]            r_reads;
    logic                  r_fifo_re;
    logic                  r_re_d;
    logic [1:0]            r_occ;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_buf [0:1];

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_wvalid;
    logic                  w_last_beat;
    logic [8:0]            w_n;
    logic [1:0]            w_occ_next;
    logic                  w_prefetch_ok;
    logic                  w_unused_bid;

    assign w_accept      = (r_state == S_IDLE) && wr_burst_req;
    assign w_n           = {1'b0, r_awlen} + 9'd1;
    assign w_wvalid      = (r_state == S_W) && (r_occ != 2'd0);
    assign w_last_beat   = (r_beats == {1'b0, r_awlen});
    // Data requested last cycle lands in the buffer at the end of this one.
    assign w_push        = r_re_d;
    assign w_pop         = w_wvalid && m_axi_wready;
    assign w_occ_next    = r_occ + 2'(w_push) - 2'(w_pop);
    // Buffered entries plus the read still in flight must leave room for one more.
    assign w_prefetch_ok = ((r_state == S_AW) || (r_state == S_W)) && (r_reads < w_n) &&
                           ((3'(w_occ_next) + 3'(r_fifo_re)) < 3'd2);
    assign w_unused_bid  = ^m_axi_bid;

    assign wr_ready        = (r_state == S_IDLE) && !ui_rst;
    assign wr_fifo_re      = r_fifo_re;
    assign wr_burst_finish = r_finish;
    assign wr_err          = r_err;
    assign m_axi_awid      = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr    = r_awaddr;
    assign m_axi_awlen     = r_awlen;
    assign m_axi_awsize    = 3'(SIZE_LOG2);
    assign m_axi_awburst   = 2'b01;
    assign m_axi_awvalid   = r_awvalid;
    assign m_axi_wdata     = r_buf[r_rd_ptr];
    assign m_axi_wstrb     = '1;
    assign m_axi_wvalid    = w_wvalid;
    assign m_axi_wlast     = w_wvalid && w_last_beat;
    assign m_axi_bready    = r_bready;

    // Burst sequencing: request latch, AW/B handshakes, finish pulse and error flags.
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_state   <= S_IDLE;
            r_awaddr  <= 32'h0;
            r_awlen   <= 8'h0;
            r_awvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_finish  <= 1'b0;
            r_err     <= 2'b00;
            r_beats   <= 9'd0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_burst_req) begin
                        r_awaddr <= (wr_burst_addr << ADDR_SHIFT) + BASE_ADDR;
                        if (wr_burst_len[9:8] != 2'b00) begin
                            r_awlen  <= 8'hFF;
                            r_err[1] <= 1'b1;
                        end else begin
                            r_awlen <= wr_burst_len[7:0];
                        end
                        r_awvalid <= 1'b1;
                        r_beats   <= 9'd0;
                        r_state   <= S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (w_pop) begin
                        r_beats <= r_beats + 9'd1;
                        if (w_last_beat) begin
                            r_bready <= 1'b1;
                            r_state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_err[0] <= r_err[0] | (m_axi_bresp != 2'b00);
                        r_finish <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_HOLD;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO prefetch control and skid-buffer occupancy/pointers.
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            r_fifo_re <= 1'b0;
            r_re_d    <= 1'b0;
            r_occ     <= 2'd0;
            r_rd_ptr  <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_reads   <= 9'd0;
        end else begin
            r_re_d <= r_fifo_re;
            r_occ  <= w_occ_next;
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (w_accept) begin
                r_reads   <= 9'd0;
                r_fifo_re <= 1'b0;
            end else if (w_prefetch_ok) begin
                r_reads   <= r_reads + 9'd1;
                r_fifo_re <= 1'b1;
            end else begin
                r_fifo_re <= 1'b0;
            end
        end
    end

    // Skid-buffer storage; data only, no reset needed.
    always_ff @(posedge ui_clk) begin
        if (w_push) r_buf[r_wr_ptr] <= wr_fifo_data;
    end

endmodule

// File: tb/tb_axi_wr_master.sv
// Directed bench for axi_wr_master: FIFO model with read latency 1, AXI slave
// with configurable AW stall / random W backpressure / B delay, and a monitor.
module tb_axi_wr_master;

    logic         ui_clk = 1'b0;
    logic         ui_rst;
    logic         wr_burst_req;
    logic [31:0]  wr_burst_addr;
    logic [9:0]   wr_burst_len;
    logic         wr_ready;
    logic         wr_fifo_re;
    logic [255:0] wr_fifo_data;
    logic         wr_burst_finish;
    logic [1:0]   wr_err;
    logic [3:0]   m_axi_awid;
    logic [31:0]  m_axi_awaddr;
    logic [7:0]   m_axi_awlen;
    logic [2:0]   m_axi_awsize;
    logic [1:0]   m_axi_awburst;
    logic         m_axi_awvalid;
    logic         m_axi_awready;
    logic [255:0] m_axi_wdata;
    logic [31:0]  m_axi_wstrb;
    logic         m_axi_wlast;
    logic         m_axi_wvalid;
    logic         m_axi_wready;
    logic [3:0]   m_axi_bid;
    logic [1:0]   m_axi_bresp;
    logic         m_axi_bvalid;
    logic         m_axi_bready;

    axi_wr_master dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_ready(wr_ready), .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
        .wr_burst_finish(wr_burst_finish), .wr_err(wr_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus configuration (written by tasks only)
    logic [15:0] cur_tag = 16'h0;
    int          exp_n = 1;
    int          cfg_aw_delay = 0;
    bit          cfg_w_rand = 1'b0;
    int          cfg_b_delay = 2;
    bit          clr = 1'b0;

    // monitor state (written by the monitor only)
    int          cyc = 0;
    int          aw_wait = 0;
    int          beat_cnt, data_bad, wlast_bad, re_cnt, stab_bad, aw_stab_bad, early_w;
    int          re_before_aw, aw_stall, fin_cnt, b_cyc, fin_cyc, rdy_cyc, wl_cyc;
    bit          aw_done, aw_seen, b_pending, rdy_seen, prev_w_stall, prev_aw_stall;
    logic [31:0] aw_addr_s, p_awaddr;
    logic [7:0]  aw_len_s, p_awlen;
    logic [2:0]  aw_size_s;
    logic [1:0]  aw_burst_s;
    logic [3:0]  aw_id_s;
    logic [255:0] p_wdata;
    logic        p_wlast;
    int          fifo_idx = 0;

    function automatic logic [255:0] beat_data(input logic [15:0] t, input int i);
        logic [15:0] ii;
        ii = i[15:0];
        return {8{t, ii}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: data appears the cycle after the read strobe
    always @(posedge ui_clk) begin
        if (clr) fifo_idx = 0;
        else if (wr_fifo_re) begin
            wr_fifo_data <= beat_data(cur_tag, fifo_idx);
            fifo_idx = fifo_idx + 1;
        end
    end

    // AXI slave responder, driven just after each rising edge
    always @(posedge ui_clk) begin
        cyc = cyc + 1;
        #1;
        if (!m_axi_awvalid) begin
            aw_wait = 0;
            m_axi_awready = 1'b1;
        end else if (aw_wait < cfg_aw_delay) begin
            aw_wait = aw_wait + 1;
            m_axi_awready = 1'b0;
        end else begin
            m_axi_awready = 1'b1;
        end
        m_axi_wready = cfg_w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_bvalid = b_pending && (cyc >= wl_cyc + cfg_b_delay);
    end

    // Monitor: samples on the falling edge
    always @(negedge ui_clk) begin
        if (clr) begin
            beat_cnt = 0; data_bad = 0; wlast_bad = 0; re_cnt = 0; stab_bad = 0;
            aw_stab_bad = 0; early_w = 0; re_before_aw = 0; aw_stall = 0; fin_cnt = 0;
            b_cyc = 0; fin_cyc = 0; rdy_cyc = 0; wl_cyc = 0;
            aw_done = 0; aw_seen = 0; b_pending = 0; rdy_seen = 0;
            prev_w_stall = 0; prev_aw_stall = 0;
        end else if (!ui_rst) begin
            if (wr_fifo_re) begin
                re_cnt++;
                if (!aw_done) re_before_aw++;
            end
            if (m_axi_wvalid && !aw_done) early_w++;
            if (m_axi_awvalid) begin
                if (!aw_seen) begin
                    aw_addr_s = m_axi_awaddr; aw_len_s = m_axi_awlen; aw_size_s = m_axi_awsize;
                    aw_burst_s = m_axi_awburst; aw_id_s = m_axi_awid;
                end
                aw_seen = 1;
                if (prev_aw_stall && (m_axi_awaddr != p_awaddr || m_axi_awlen != p_awlen))
                    aw_stab_bad++;
                if (!m_axi_awready) aw_stall++;
                else aw_done = 1;
            end else if (prev_aw_stall) aw_stab_bad++;
            prev_aw_stall = m_axi_awvalid && !m_axi_awready;
            p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;

            if (prev_w_stall && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wlast != p_wlast))
                stab_bad++;
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata != beat_data(cur_tag, beat_cnt)) data_bad++;
                if (m_axi_wlast != (beat_cnt == exp_n - 1)) wlast_bad++;
                if (m_axi_wlast) begin
                    b_pending = 1;
                    wl_cyc = cyc;
                end
                beat_cnt++;
            end
            prev_w_stall = m_axi_wvalid && !m_axi_wready;
            p_wdata = m_axi_wdata; p_wlast = m_axi_wlast;

            if (m_axi_bvalid && m_axi_bready) begin
                b_pending = 0;
                b_cyc = cyc;
            end
            if (fin_cnt > 0 && !rdy_seen && wr_ready) begin
                rdy_seen = 1;
                rdy_cyc = cyc;
            end
            if (wr_burst_finish) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
        end
    end

    task automatic start_burst(input logic [31:0] addr, input logic [9:0] len, input logic [15:0] tag,
                               input int aw_delay, input bit w_rand, input logic [1:0] bresp);
        cur_tag = tag;
        exp_n = (len > 10'd255) ? 256 : int'(len) + 1;
        cfg_aw_delay = aw_delay;
        cfg_w_rand = w_rand;
        m_axi_bresp = bresp;
        @(posedge ui_clk); #2 clr = 1'b1;
        repeat (2) @(posedge ui_clk);
        #2 clr = 1'b0;
        for (int i = 0; i < 50 && !wr_ready; i++) @(negedge ui_clk);
        chk("ready_wait", 64'(wr_ready), 64'd1);
        @(posedge ui_clk); #1;
        wr_burst_req = 1'b1; wr_burst_addr = addr; wr_burst_len = len;
        @(posedge ui_clk); #1;
        wr_burst_req = 1'b0;
    endtask

    task automatic finish_burst(input string nm);
        for (int i = 0; i < 4000 && fin_cnt == 0; i++) @(negedge ui_clk);
        chk({nm, "_done"}, 64'(fin_cnt != 0), 64'd1);
        repeat (4) @(negedge ui_clk);
        chk({nm, "_beats"}, 64'(beat_cnt), 64'(exp_n));
        chk({nm, "_re_cnt"}, 64'(re_cnt), 64'(exp_n));
        chk({nm, "_data_bad"}, 64'(data_bad), 64'd0);
        chk({nm, "_wlast_bad"}, 64'(wlast_bad), 64'd0);
        chk({nm, "_stable_bad"}, 64'(stab_bad), 64'd0);
        chk({nm, "_early_w"}, 64'(early_w), 64'd0);
        chk({nm, "_fin_cnt"}, 64'(fin_cnt), 64'd1);
    endtask

    initial begin
        ui_rst = 1'b1; wr_burst_req = 1'b0; wr_burst_addr = 32'h0; wr_burst_len = 10'h0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b0;
        m_axi_bresp = 2'b00; m_axi_bid = 4'h0; wr_fifo_data = '0;
        repeat (3) @(negedge ui_clk);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_re", 64'(wr_fifo_re), 64'd0);
        chk("rst_err", 64'(wr_err), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        @(posedge ui_clk); #2 ui_rst = 1'b0;
        @(negedge ui_clk);
        chk("post_rst_ready", 64'(wr_ready), 64'd1);

        // 1: basic burst, address mapping and response timing
        start_burst(32'h80, 10'd15, 16'hA001, 0, 1'b0, 2'b00);
        finish_burst("t1");
        chk("t1_awaddr", 64'(aw_addr_s), 64'h200);
        chk("t1_awlen", 64'(aw_len_s), 64'd15);
        chk("t1_awsize", 64'(aw_size_s), 64'd5);
        chk("t1_awburst", 64'(aw_burst_s), 64'd1);
        chk("t1_awid", 64'(aw_id_s), 64'd0);
        chk("t1_wstrb", 64'(&m_axi_wstrb), 64'd1);
        chk("t1_fin_lat", 64'(fin_cyc - b_cyc), 64'd1);
        chk("t1_rdy_lat", 64'(rdy_cyc - fin_cyc), 64'd2);
        chk("t1_err", 64'(wr_err), 64'd0);

        // 2: random W backpressure
        start_burst(32'h1234, 10'd15, 16'hB002, 0, 1'b1, 2'b00);
        finish_burst("t2");

        // 3: AW stalled for 5 cycles
        start_burst(32'h40, 10'd7, 16'hC003, 5, 1'b0, 2'b00);
        finish_burst("t3");
        chk("t3_aw_stall", 64'(aw_stall), 64'd5);
        chk("t3_aw_stable", 64'(aw_stab_bad), 64'd0);
        chk("t3_prefetch", 64'(re_before_aw), 64'd2);
        chk("t3_awaddr", 64'(aw_addr_s), 64'h100);

        // 4: SLVERR response
        start_burst(32'h10, 10'd3, 16'hD004, 0, 1'b0, 2'b10);
        finish_burst("t4");
        chk("t4_err", 64'(wr_err), 64'd1);

        // 5: oversize length clamps to 256 beats
        start_burst(32'h1000, 10'd300, 16'hE005, 0, 1'b0, 2'b00);
        finish_burst("t5");
        chk("t5_awlen", 64'(aw_len_s), 64'd255);
        chk("t5_err", 64'(wr_err), 64'd3);

        // 6: reset in the middle of the W phase
        start_burst(32'h20, 10'd15, 16'hF006, 0, 1'b0, 2'b00);
        for (int i = 0; i < 200 && beat_cnt < 7; i++) @(negedge ui_clk);
        chk("t6_reach_beat7", 64'(beat_cnt), 64'd7);
        #1 ui_rst = 1'b1;
        #1;
        chk("t6_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("t6_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("t6_wlast", 64'(m_axi_wlast), 64'd0);
        chk("t6_bready", 64'(m_axi_bready), 64'd0);
        chk("t6_re", 64'(wr_fifo_re), 64'd0);
        chk("t6_finish", 64'(wr_burst_finish), 64'd0);
        chk("t6_err", 64'(wr_err), 64'd0);
        repeat (2) @(posedge ui_clk);
        #2 ui_rst = 1'b0;
        @(negedge ui_clk);
        chk("t6_ready", 64'(wr_ready), 64'd1);
        start_burst(32'h300, 10'd15, 16'h7007, 0, 1'b0, 2'b00);
        finish_burst("t6b");
        chk("t6b_awaddr", 64'(aw_addr_s), 64'hC00);
        chk("t6b_err", 64'(wr_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
